// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states,
// and small decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic op_is_div(op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add for multiply,
// restoring shift-subtract for divide. {acc,q} is the 2*WIDTH working pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   cand;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, m};
    cand    = {acc, q[WIDTH-1]};
    // only consumed when cand >= m, where the true difference fits in WIDTH bits
    diff    = cand[WIDTH-1:0] - m;
    acc_nxt = acc;
    q_nxt   = q;
    if (is_div) begin
      if (cand >= {1'b0, m}) begin
        acc_nxt = diff;
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = cand[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end else if (q[0]) begin
      {acc_nxt, q_nxt} = {sum, q[WIDTH-1:1]};
    end else begin
      {acc_nxt, q_nxt} = {1'b0, acc, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide: PREP forms magnitudes, RUN
// iterates WIDTH times, FIX restores signs and registers hi/lo.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state;
  op_e              op_r;
  logic [WIDTH-1:0] a_r, b_r, acc, q, m;
  logic             neg_p, neg_r;
  logic [CW-1:0]    cnt;

  logic               div_op, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b, acc_nxt, q_nxt, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    div_op   = op_is_div(op_r);
    sa       = op_is_signed(op_r) & a_r[WIDTH-1];
    sb       = op_is_signed(op_r) & b_r[WIDTH-1];
    mag_a    = sa ? -a_r : a_r;
    mag_b    = sb ? -b_r : b_r;
    prod_fix = neg_p ? -{acc, q} : {acc, q};
    q_fix    = neg_p ? -q : q;
    r_fix    = neg_r ? -acc : acc;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (div_op),
    .acc     (acc),
    .q       (q),
    .m       (m),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r     <= op_e'(op);
            a_r      <= a;
            b_r      <= b;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= S_PREP;
          end
        end
        S_PREP: begin
          if (div_op && b_r == '0) begin
            // divide by zero skips the datapath; hi/lo keep the last result
            div_zero <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            acc   <= '0;
            q     <= mag_a;
            m     <= mag_b;
            neg_p <= sa ^ sb;
            neg_r <= sa;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (div_op) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal values 4..64).
REQ-002 SHALL have port clk, input, 1, the single clock; every flop is rising-edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1, a request that is accepted only in IDLE.
REQ-005 SHALL have port op, input, 2, operation: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 SHALL have port a, input, WIDTH, multiplicand or dividend.
REQ-007 SHALL have port b, input, WIDTH, multiplier or divisor.
REQ-008 SHALL have port busy, output, 1, high in PREP, RUN and FIX.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse in DONE.
REQ-010 SHALL have port hi, output, WIDTH: product upper half, or remainder.
REQ-011 SHALL have port lo, output, WIDTH: product lower half, or quotient.
REQ-012 SHALL have port div_zero, output, 1, set when a division by zero is attempted.

Function
REQ-013 SHALL implement the FSM IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE, registered.
REQ-014 SHALL, in IDLE with start=1 at an edge, latch op, a and b and enter PREP; later changes on a, b and op are ignored.
REQ-015 SHALL ignore start in every state except IDLE, with no queuing.
REQ-016 SHALL, in PREP, form operand magnitudes (signed ops take the absolute value; unsigned ops pass through) and record the result signs.
REQ-017 SHALL iterate in RUN for exactly WIDTH cycles: radix-2 shift-add for multiply, restoring shift-subtract for divide, on magnitudes.
REQ-018 SHALL, in FIX, apply the sign rules and register hi and lo.
- Product is negated when the operand signs differ.
- Quotient is negative when the signs differ; the remainder takes the sign of the dividend.
REQ-019 SHALL assert done in the cycle after FIX, so done is high WIDTH+3 edges after the accepting edge.
REQ-020 SHALL, for DIV or DIVU with b=0, go PREP -> DONE, set div_zero=1 and leave hi and lo unchanged; done is then high 2 edges after the accepting edge.
REQ-021 SHALL return lo = 2^(WIDTH-1) pattern and hi = 0 for signed DIV of most-negative by -1, with no flag.
REQ-022 SHALL hold hi and lo until the next successful completion, and hold div_zero until the next accepted start, which clears it.
REQ-023 SHALL compute the product at 2*WIDTH bits internally with no truncation; MULTU of all-ones operands SHALL produce no overflow.

Reset
REQ-024 SHALL, with reset=0 at an edge, force IDLE and set busy=0, done=0, hi=0, lo=0 and div_zero=0, whatever the current state.
REQ-025 SHALL abandon an operation that is reset mid-flight; start is ignored while reset=0.

Structure
REQ-026 SHALL place the op encodings and the FSM state enumeration in shared package muldiv_pkg.
REQ-027 SHALL implement one iteration step (add/shift or subtract/shift) as sub-module muldiv_step, parameterised by WIDTH.
REQ-028 SHALL size the iteration counter as clog2(WIDTH)+1 bits.

Verification (WIDTH=32 unless noted)
REQ-029 SHALL cover: MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done 35 edges after start.
REQ-030 SHALL cover: MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL cover:
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 SHALL cover: DIVU a=100, b=0 after a prior result -> div_zero=1, done 2 edges after start, hi and lo unchanged.
REQ-033 SHALL cover: start, reset=0 in RUN cycle 10 -> next cycle busy=0, hi=lo=0; start pulsed while busy -> no effect on the result.
REQ-034 SHALL cover: WIDTH=8 instance, MULT a=0x80, b=0x80 -> hi=0x40, lo=0x00, done 11 edges after start.
